// File: rtl/bias_ctrl_pkg.sv
// bias_ctrl_pkg: types and constants shared by the bias BRAM sequencer.
//   state_t    - controller FSM states
//   clogb2     - number of bits needed to hold a value
//   DEF_*      - default bias word width and BRAM depth
package bias_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, DRAIN} state_t;

  localparam int DEF_DATA_W = 40;
  localparam int DEF_DEPTH  = 49;

  function automatic int clogb2(input int value);
    int v;
    int r;
    v = value;
    for (r = 0; v > 0; r++) v = v >> 1;
    return r;
  endfunction

endpackage

// File: rtl/bias_out_fifo.sv
// bias_out_fifo: synchronous FIFO with registered storage and an occupancy count.
//   clk, rst   - clock, asynchronous active-high reset (storage cleared too,
//                so dout reads 0 out of reset)
//   push, din  - write side; the caller never pushes when full
//   pop, dout  - read side; dout shows the head entry, caller pops only when count != 0
//   count      - number of entries held (0..DEPTH)
module bias_out_fifo #(
  parameter int W     = 41,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/bias_bram_ctrl.sv
// bias_bram_ctrl: sequencer for the bias BRAM (true dual-port, 2-cycle read).
//   Loads N bias words from the ld_* stream through port A, then on run_start
//   streams N words in address order through port B into a credit-controlled
//   output FIFO feeding the out_* stream.
// Ports:
//   clk, rst                    - clock, asynchronous active-high reset
//   cfg_num                     - word count, sampled on an accepted start
//   load_start, run_start       - single-cycle start pulses (load has priority)
//   ld_valid/ld_ready/ld_data   - load stream
//   out_valid/out_ready/out_data/out_last - bias output stream
//   busy, loaded, err           - status (err sticky)
//   ram_ena/wea/addra/dina      - BRAM port A (write)
//   ram_enb/addrb/regceb/rstb   - BRAM port B (read), ram_doutb read data
// Optional feature: define BIAS_CTRL_ERR_EN to enable the sticky err flag
// (ignored start, or ld_valid while idle). Without it err is tied 0.
module bias_bram_ctrl
  import bias_ctrl_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_W     = clogb2(DEPTH - 1),
  parameter int CNT_W      = clogb2(DEPTH),
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  cfg_num,
  input  logic              load_start,
  input  logic              run_start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              loaded,
  output logic              err,
  output logic              ram_ena,
  output logic              ram_wea,
  output logic [ADDR_W-1:0] ram_addra,
  output logic [DATA_W-1:0] ram_dina,
  output logic              ram_enb,
  output logic [ADDR_W-1:0] ram_addrb,
  output logic              ram_regceb,
  output logic              ram_rstb,
  input  logic [DATA_W-1:0] ram_doutb
);

  localparam int RD_LAT = 2;
  localparam int FCW    = $clog2(FIFO_DEPTH) + 1;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  n_q, n_d, n_loaded_q, n_loaded_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              loaded_q, loaded_d;
  logic [RD_LAT:1]   vld_pipe_q, vld_pipe_d, last_pipe_q, last_pipe_d;

  logic              ld_ok, run_ok, ld_hs, issue, last_addr, credit;
  logic [FCW-1:0]    fifo_count;
  logic [FCW:0]      occ;
  logic [DATA_W:0]   fifo_dout;

  // Occupancy counts reads still in the BRAM pipeline so the FIFO can never
  // overflow regardless of out_ready.
  assign occ    = {1'b0, fifo_count} + (FCW+1)'(vld_pipe_q[1]) + (FCW+1)'(vld_pipe_q[2]);
  assign credit = occ < (FCW+1)'(FIFO_DEPTH);

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    n_loaded_d = n_loaded_q;
    addr_d     = addr_q;
    loaded_d   = loaded_q;

    ld_ok     = load_start && (cfg_num != '0) && (int'(cfg_num) <= DEPTH);
    run_ok    = run_start && loaded_q && (cfg_num != '0) && (cfg_num <= n_loaded_q);
    ld_hs     = (state_q == LOAD) && ld_valid;
    issue     = (state_q == STREAM) && credit;
    last_addr = (addr_q == ADDR_W'(n_q - 1'b1));

    case (state_q)
      IDLE: begin
        if (ld_ok) begin
          state_d  = LOAD;
          n_d      = cfg_num;
          loaded_d = 1'b0;
          addr_d   = '0;
        end else if (run_ok) begin
          state_d = STREAM;
          n_d     = cfg_num;
          addr_d  = '0;
        end
      end
      LOAD: begin
        if (ld_hs) begin
          addr_d = addr_q + 1'b1;
          if (last_addr) begin
            loaded_d   = 1'b1;
            n_loaded_d = n_q;
            state_d    = IDLE;
          end
        end
      end
      STREAM: begin
        if (issue) begin
          addr_d = addr_q + 1'b1;
          if (last_addr) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((vld_pipe_q == '0) && (fifo_count == '0)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    vld_pipe_d  = {vld_pipe_q[1], issue};
    last_pipe_d = {last_pipe_q[1], issue && last_addr};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      n_q         <= '0;
      n_loaded_q  <= '0;
      addr_q      <= '0;
      loaded_q    <= 1'b0;
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      n_loaded_q  <= n_loaded_d;
      addr_q      <= addr_d;
      loaded_q    <= loaded_d;
      vld_pipe_q  <= vld_pipe_d;
      last_pipe_q <= last_pipe_d;
    end
  end

`ifdef BIAS_CTRL_ERR_EN
  logic err_q, err_d;
  logic ignored;
  // A run that loses to a same-cycle load is not counted as ignored.
  always_comb begin
    ignored = (load_start && !((state_q == IDLE) && ld_ok)) ||
              (run_start && !((state_q == IDLE) && (ld_ok || run_ok))) ||
              ((state_q == IDLE) && ld_valid);
    err_d   = err_q || ignored;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Stage-2 of the valid pipe lines up with ram_doutb of the matching read.
  bias_out_fifo #(.W(DATA_W + 1), .DEPTH(FIFO_DEPTH), .CW(FCW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (vld_pipe_q[RD_LAT]),
    .din   ({last_pipe_q[RD_LAT], ram_doutb}),
    .pop   (out_valid && out_ready),
    .dout  (fifo_dout),
    .count (fifo_count)
  );

  assign out_valid  = (fifo_count != '0);
  assign out_data   = fifo_dout[DATA_W-1:0];
  assign out_last   = fifo_dout[DATA_W];
  assign ld_ready   = (state_q == LOAD);
  assign busy       = (state_q != IDLE);
  assign loaded     = loaded_q;
  assign ram_ena    = ld_hs;
  assign ram_wea    = ld_hs;
  assign ram_addra  = addr_q;
  assign ram_dina   = ld_data;
  assign ram_enb    = issue;
  assign ram_addrb  = addr_q;
  assign ram_regceb = 1'b1;
  assign ram_rstb   = 1'b0;

endmodule

// File: tb/tb_bias_bram_ctrl.sv
module tb_bias_bram_ctrl;

  localparam int DATA_W = 40;
  localparam int ADDR_W = 6;
  localparam int CNT_W  = 6;
  localparam logic [DATA_W-1:0] BASE = 40'hA000000000;

`ifdef BIAS_CTRL_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [CNT_W-1:0]  cfg_num;
  logic              load_start, run_start;
  logic              ld_valid, ld_ready;
  logic [DATA_W-1:0] ld_data;
  logic              out_valid, out_ready, out_last;
  logic [DATA_W-1:0] out_data;
  logic              busy, loaded, err;
  logic              ram_ena, ram_wea, ram_enb, ram_regceb, ram_rstb;
  logic [ADDR_W-1:0] ram_addra, ram_addrb;
  logic [DATA_W-1:0] ram_dina, ram_doutb;

  int n_cmp = 0;
  int n_err = 0;
  logic [DATA_W:0] exp_q[$];

  always #5 clk = ~clk;

  bias_bram_ctrl dut (
    .clk(clk), .rst(rst), .cfg_num(cfg_num), .load_start(load_start), .run_start(run_start),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .loaded(loaded), .err(err),
    .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dina(ram_dina),
    .ram_enb(ram_enb), .ram_addrb(ram_addrb), .ram_regceb(ram_regceb), .ram_rstb(ram_rstb),
    .ram_doutb(ram_doutb)
  );

  // Bias BRAM model: 2-cycle read (array read + output register).
  logic [DATA_W-1:0] bram [64];
  logic [DATA_W-1:0] rd1;
  always @(posedge clk) begin
    if (ram_ena && ram_wea) bram[ram_addra] <= ram_dina;
    if (ram_enb) rd1 <= bram[ram_addrb];
    if (ram_regceb) ram_doutb <= rd1;
  end

  task automatic test_reset();
    rst = 1'b1; cfg_num = '0; load_start = 0; run_start = 0;
    ld_valid = 0; ld_data = '0; out_ready = 0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if ({ld_ready, out_valid, out_last, busy, loaded, err} !== 6'b0) begin
      n_err++; $display("FAIL reset_status got=%b want=000000", {ld_ready, out_valid, out_last, busy, loaded, err});
    end
    n_cmp++; if (out_data !== '0) begin
      n_err++; $display("FAIL reset_out_data got=%h want=0", out_data);
    end
    n_cmp++; if ({ram_ena, ram_wea, ram_enb, ram_addra, ram_addrb} !== 15'b0) begin
      n_err++; $display("FAIL reset_ram got=%b want=0", {ram_ena, ram_wea, ram_enb, ram_addra, ram_addrb});
    end
    n_cmp++; if ({ram_regceb, ram_rstb} !== 2'b10) begin
      n_err++; $display("FAIL reset_regce_rstb got=%b want=10", {ram_regceb, ram_rstb});
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic try_start(input string name, input int n, input logic ld, input logic rn);
    @(negedge clk); cfg_num = CNT_W'(n); load_start = ld; run_start = rn;
    @(negedge clk); load_start = 0; run_start = 0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin
      n_err++; $display("FAIL %s_busy got=%b want=0", name, busy);
    end
    repeat (2) @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || ram_enb !== 1'b0) begin
      n_err++; $display("FAIL %s_idle got busy=%b enb=%b want 0,0", name, busy, ram_enb);
    end
  endtask

  task automatic test_ignored();
    try_start("run_unloaded", 5, 1'b0, 1'b1);
    try_start("load_num0", 0, 1'b1, 1'b0);
    try_start("load_num50", 50, 1'b1, 1'b0);
    n_cmp++; if (err !== ERR_EXP) begin
      n_err++; $display("FAIL err_flag got=%b want=%b", err, ERR_EXP);
    end
  endtask

  // Load n words BASE+i; with_run raises run_start alongside load_start.
  task automatic load_words(input string name, input int n, input logic with_run);
    int i, guard;
    @(negedge clk); cfg_num = CNT_W'(n); load_start = 1; run_start = with_run;
    @(negedge clk); load_start = 0; run_start = 0;
    #1;
    n_cmp++; if ({busy, ld_ready, loaded} !== 3'b110) begin
      n_err++; $display("FAIL %s_enter got busy,ready,loaded=%b want=110", name, {busy, ld_ready, loaded});
    end
    i = 0; guard = 0;
    while (i < n && guard < 1000) begin
      ld_valid = ($urandom_range(0, 3) != 0);
      ld_data  = BASE + DATA_W'(i);
      #1;
      if (ld_valid && ld_ready) i++;
      @(negedge clk); guard++;
    end
    ld_valid = 0;
    #1;
    n_cmp++; if (i != n) begin
      n_err++; $display("FAIL %s_timeout got=%0d words want=%0d", name, i, n);
    end
    n_cmp++; if ({loaded, busy, ld_ready} !== 3'b100) begin
      n_err++; $display("FAIL %s_done got loaded,busy,ready=%b want=100", name, {loaded, busy, ld_ready});
    end
  endtask

  // mode 0: out_ready held high, latency and no-bubble checks.
  // mode 1: random out_ready plus a 20-cycle stall.
  // stop_after > 0: return after that many words have been taken.
  task automatic run_stream(input string name, input int n, input int mode, input int stop_after);
    int cyc, popped;
    logic stalled, seen_valid;
    logic [DATA_W:0] held, exp;
    for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), BASE + DATA_W'(i)});
    @(negedge clk); cfg_num = CNT_W'(n); run_start = 1;
    out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    @(negedge clk); run_start = 0;
    #1;
    n_cmp++; if ({busy, ram_enb, ram_addrb} !== {2'b11, 6'd0}) begin
      n_err++; $display("FAIL %s_first_issue got busy,enb,addrb=%b want=11000000", name, {busy, ram_enb, ram_addrb});
    end
    cyc = 1; popped = 0; stalled = 0; seen_valid = 0; held = '0;
    while (exp_q.size() > 0 && cyc < 3000 && !(stop_after > 0 && popped == stop_after)) begin
      if (mode == 0 && ((cyc < 4 && out_valid) || (cyc >= 4 && !out_valid))) begin
        n_cmp++; n_err++;
        $display("FAIL %s_timing cyc=%0d got out_valid=%b want=%b", name, cyc, out_valid, cyc >= 4);
      end
      if (stalled) begin
        n_cmp++; if (out_valid !== 1'b1 || {out_last, out_data} !== held) begin
          n_err++; $display("FAIL %s_stall_hold got v=%b %h want v=1 %h", name, out_valid, {out_last, out_data}, held);
        end
      end
      if (out_valid && out_ready) begin
        exp = exp_q.pop_front();
        n_cmp++; if ({out_last, out_data} !== exp) begin
          n_err++; $display("FAIL %s_word%0d got=%h want=%h", name, popped, {out_last, out_data}, exp);
        end
        popped++;
      end
      seen_valid = seen_valid | out_valid;
      stalled = out_valid && !out_ready;
      held = {out_last, out_data};
      @(negedge clk);
      if (mode == 1) out_ready = (cyc >= 10 && cyc < 30) ? 1'b0 : 1'($urandom_range(0, 1));
      #1; cyc++;
    end
    n_cmp++; if (popped != ((stop_after > 0) ? stop_after : n)) begin
      n_err++; $display("FAIL %s_count got=%0d want=%0d", name, popped, (stop_after > 0) ? stop_after : n);
    end
    if (stop_after == 0) begin
      for (int k = 0; k < 20 && busy; k++) begin @(negedge clk); #1; end
      n_cmp++; if ({busy, out_valid, loaded} !== 3'b001) begin
        n_err++; $display("FAIL %s_end got busy,valid,loaded=%b want=001", name, {busy, out_valid, loaded});
      end
      out_ready = 0;
    end
  endtask

  task automatic test_full();
    load_words("load49", 49, 1'b0);
    run_stream("run49", 49, 0, 0);
  endtask

  task automatic test_backpressure();
    run_stream("bp49", 49, 1, 0);
  endtask

  task automatic test_short();
    run_stream("run5", 5, 0, 0);
  endtask

  task automatic test_collision();
    load_words("collide", 49, 1'b1);
  endtask

  task automatic test_reset_mid();
    run_stream("pre_rst", 49, 0, 10);
    @(negedge clk); rst = 1'b1; out_ready = 0;
    #1;
    n_cmp++; if ({busy, loaded, out_valid, err} !== 4'b0) begin
      n_err++; $display("FAIL midrst_state got busy,loaded,valid,err=%b want=0000", {busy, loaded, out_valid, err});
    end
    exp_q.delete();
    @(negedge clk); rst = 1'b0;
    try_start("run_after_rst", 49, 1'b0, 1'b1);
    load_words("reload", 49, 1'b0);
    run_stream("rerun", 49, 0, 0);
  endtask

  initial begin
    test_reset();
    test_ignored();
    test_full();
    test_backpressure();
    test_short();
    test_collision();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
